// File: rtl/pipo_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// pipo_serializer_ctrl
//
// Purpose:
//   Controls a parallel-load shift register so that it works as a
//   parallel-to-serial converter. A WIDTH-bit word is taken over a
//   valid/ready handshake and then presented one bit at a time. The
//   downstream consumer paces each bit with ser_en. When the last bit of a
//   word is consumed and another word is waiting, that word is loaded on
//   the same edge. This gives back-to-back words with no idle cycle.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   par_valid  upstream word available on par_data
//   par_data   parallel word to serialize
//   par_ready  word is taken on this edge if par_valid=1
//   ser_en     downstream consumes the presented bit on this edge
//   ser_out    presented serial bit (meaningful while ser_valid=1)
//   ser_valid  a serial bit is presented
//   ser_last   presented bit is the final bit of the word
//   busy       a word is in flight
// ---------------------------------------------------------------------------
module pipo_serializer_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             par_valid,
    input  logic [WIDTH-1:0] par_data,
    output logic             par_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg_shifted;
    logic               in_shift;
    logic               at_last;

    // The shift direction moves the next bit toward the output end and
    // zero-fills the bit that is vacated at the far end.
    always_comb begin
        shreg_shifted = shreg;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // The presentation outputs decode only from flops. That keeps them
    // glitch-free for the consumer. Because state resets asynchronously,
    // ser_valid drops as soon as reset_n is asserted. par_ready is the one
    // combinational exception. It must also open on the consuming edge of
    // the last bit so that a waiting word can be loaded without a bubble.
    // It deliberately does not look at par_valid.
    always_comb begin
        in_shift  = (state == SHIFT);
        at_last   = in_shift && (bit_cnt == LAST_IDX);
        ser_valid = in_shift;
        busy      = in_shift;
        ser_last  = at_last;
        ser_out   = in_shift && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
        par_ready = !in_shift || (at_last && ser_en);
    end

    // Sequencing FSM. IDLE waits for a word. SHIFT presents bits and
    // advances one position per ser_en. At the end of a word it either
    // reloads from a waiting upstream word or falls back to IDLE. Clearing
    // shreg on the way to IDLE matches the zero fill of a final shift. No
    // stale data is therefore left behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (par_valid) begin
                        shreg   <= par_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        if (bit_cnt == LAST_IDX) begin
                            bit_cnt <= '0;
                            if (par_valid) begin
                                shreg <= par_data;
                            end else begin
                                shreg <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            shreg   <= shreg_shifted;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipo_serializer_ctrl
//
// Purpose:
//   Self-checking bench for pipo_serializer_ctrl. Two instances share all
//   inputs: dut_m sends the MSB first and dut_l sends the LSB first. The
//   reference model tracks each instance as "a word plus the number of
//   bits still to deliver". Consumed bits are also collected from the DUT
//   outputs. Each collected stream is compared with the expected bit order.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_pipo_serializer_ctrl;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         par_valid = 1'b0;
    logic [W-1:0] par_data  = '0;
    logic         ser_en    = 1'b0;

    logic pr_m, so_m, sv_m, sl_m, b_m;
    logic pr_l, so_l, sv_l, sl_l, b_l;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = MSB-first, index 1 = LSB-first.
    int           rem   [2] = '{0, 0};
    logic [W-1:0] mword [2] = '{4'h0, 4'h0};

    // Collected consumed bits, oldest bit at the highest occupied position.
    logic [15:0] gotbits [2] = '{16'h0, 16'h0};
    int          gotn    [2] = '{0, 0};
    int          acc     [2] = '{0, 0};

    pipo_serializer_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .reset_n   (reset_n),
        .par_valid (par_valid),
        .par_data  (par_data),
        .par_ready (pr_m),
        .ser_en    (ser_en),
        .ser_out   (so_m),
        .ser_valid (sv_m),
        .ser_last  (sl_m),
        .busy      (b_m)
    );

    pipo_serializer_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .reset_n   (reset_n),
        .par_valid (par_valid),
        .par_data  (par_data),
        .par_ready (pr_l),
        .ser_en    (ser_en),
        .ser_out   (so_l),
        .ser_valid (sv_l),
        .ser_last  (sl_l),
        .busy      (b_l)
    );

    wire [4:0] dv0 = {sv_m, sl_m, so_m, pr_m, b_m};
    wire [4:0] dv1 = {sv_l, sl_l, so_l, pr_l, b_l};

    always #5 clk = ~clk;

    // Behavioural model: a word is in flight while bits remain. A consume
    // either delivers one more bit or, on the final bit, hands over to a
    // waiting word. Reset throws away whatever is left.
    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                rem[k] = 0;
            end else if (rem[k] == 0) begin
                if (par_valid) begin
                    mword[k] = par_data;
                    rem[k]   = W;
                end
            end else if (ser_en) begin
                if (rem[k] == 1 && par_valid) begin
                    mword[k] = par_data;
                    rem[k]   = W;
                end else begin
                    rem[k] = rem[k] - 1;
                end
            end
        end
    end

    // Expected {ser_valid, ser_last, ser_out, par_ready, busy} for instance k.
    function automatic logic [4:0] exp_vec(int k);
        logic v, l, o, r;
        int   p;
        v = (rem[k] > 0);
        l = (rem[k] == 1);
        p = W - rem[k];
        o = 1'b0;
        if (v) o = (k == 0) ? mword[k][W-1-p] : mword[k][p];
        r = !v || (l && ser_en);
        return {v, l, o, r, v};
    endfunction

    // Word re-ordered so that the first transmitted bit sits at bit 3.
    function automatic logic [3:0] tx_order(logic [3:0] w, bit msb);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[3-i] = msb ? w[3-i] : w[i];
        return r;
    endfunction

    task automatic clear_capture();
        for (int k = 0; k < 2; k++) begin
            gotbits[k] = '0;
            gotn[k]    = 0;
            acc[k]     = 0;
        end
    endtask

    // Drives one cycle of inputs on the falling edge, then records any bit
    // that the next rising edge will consume.
    task automatic drive(input logic pv, input logic [3:0] pd, input logic se);
        @(negedge clk);
        par_valid = pv;
        par_data  = pd;
        ser_en    = se;
        #1;
        if (sv_m && ser_en) begin gotbits[0] = {gotbits[0][14:0], so_m}; gotn[0]++; end
        if (sv_l && ser_en) begin gotbits[1] = {gotbits[1][14:0], so_l}; gotn[1]++; end
        if (par_valid && pr_m) acc[0]++;
        if (par_valid && pr_l) acc[1]++;
    endtask

    // Reset with a word offered. Nothing may load and the idle outputs must hold.
    task automatic test_reset();
        logic [4:0] got;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'hF, 1'b1);
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                checks++;
                if (got !== 5'b00010) begin
                    errors++;
                    $display("[TB] FAIL reset cyc%0d dut%0d vld/last/out/rdy/busy got=%b want=00010", c, k, got);
                end
            end
        end
        @(negedge clk);
        par_valid = 1'b0;
        reset_n   = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? dv0 : dv1;
            checks++;
            if (got !== 5'b00010) begin
                errors++;
                $display("[TB] FAIL reset_release dut%0d got=%b want=00010", k, got);
            end
        end
    endtask

    // One word, ser_en held high, covering both bit orders.
    task automatic test_single_word();
        logic [4:0] got, want;
        logic [3:0] ws;
        clear_capture();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 4'b1011, 1'b1);
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                want = exp_vec(k);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL single cyc%0d dut%0d vld/last/out/rdy/busy got=%b want=%b", c, k, got, want);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            ws = (k == 0) ? 4'b1011 : 4'b1101;
            checks++;
            if (gotn[k] != 4 || gotbits[k][3:0] !== ws) begin
                errors++;
                $display("[TB] FAIL single_stream dut%0d got=%0d bits %b want=4 bits %b", k, gotn[k], gotbits[k][3:0], ws);
            end
        end
    endtask

    // ser_en gaps must freeze the presented bit without losing any bit.
    task automatic test_stall();
        logic [4:0] got, want;
        logic [6:0] pat;
        logic [3:0] ws;
        logic       se;
        clear_capture();
        pat = 7'b1001011;
        for (int c = 0; c < 9; c++) begin
            se = (c >= 1 && c <= 7) ? pat[7-c] : 1'b0;
            drive(c == 0, 4'b1011, se);
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                want = exp_vec(k);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL stall cyc%0d dut%0d vld/last/out/rdy/busy got=%b want=%b", c, k, got, want);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            ws = tx_order(4'b1011, k == 0);
            checks++;
            if (gotn[k] != 4 || gotbits[k][3:0] !== ws) begin
                errors++;
                $display("[TB] FAIL stall_stream dut%0d got=%0d bits %b want=4 bits %b", k, gotn[k], gotbits[k][3:0], ws);
            end
        end
    endtask

    // Two words handed over with no bubble.
    task automatic test_back_to_back();
        logic [4:0] got, want;
        logic [7:0] ws;
        int         drops;
        clear_capture();
        drops = 0;
        for (int c = 0; c < 10; c++) begin
            drive(c <= 4, (c == 0) ? 4'hA : 4'h5, 1'b1);
            if (c >= 1 && c <= 8 && !(sv_m && sv_l)) drops++;
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                want = exp_vec(k);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL b2b cyc%0d dut%0d vld/last/out/rdy/busy got=%b want=%b", c, k, got, want);
                end
            end
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("[TB] FAIL b2b_bubble ser_valid low cycles got=%0d want=0", drops);
        end
        for (int k = 0; k < 2; k++) begin
            ws = {tx_order(4'hA, k == 0), tx_order(4'h5, k == 0)};
            checks++;
            if (gotn[k] != 8 || gotbits[k][7:0] !== ws || acc[k] != 2) begin
                errors++;
                $display("[TB] FAIL b2b_stream dut%0d got=%0d bits %b accepts %0d want=8 bits %b accepts 2",
                         k, gotn[k], gotbits[k][7:0], acc[k], ws);
            end
        end
    endtask

    // Reset partway through a word, then a clean follow-up word.
    task automatic test_reset_mid_word();
        logic [4:0] got, want;
        logic [3:0] ws;
        clear_capture();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 4'hC, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            ws = tx_order(4'hC, k == 0);
            checks++;
            if (gotn[k] != 2 || gotbits[k][1:0] !== ws[3:2]) begin
                errors++;
                $display("[TB] FAIL midreset_prefix dut%0d got=%0d bits %b want=2 bits %b", k, gotn[k], gotbits[k][1:0], ws[3:2]);
            end
        end
        drive(1'b0, 4'hC, 1'b1);
        #2;
        reset_n   = 1'b0;
        par_valid = 1'b1;
        par_data  = 4'hF;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? dv0 : dv1;
            checks++;
            if (got !== 5'b00010) begin
                errors++;
                $display("[TB] FAIL midreset_async dut%0d got=%b want=00010", k, got);
            end
        end
        @(negedge clk);
        reset_n   = 1'b1;
        par_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? dv0 : dv1;
            checks++;
            if (got !== 5'b00010) begin
                errors++;
                $display("[TB] FAIL midreset_release dut%0d got=%b want=00010", k, got);
            end
        end
        clear_capture();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 4'h3, 1'b1);
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                want = exp_vec(k);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL midreset_next cyc%0d dut%0d got=%b want=%b", c, k, got, want);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            ws = (k == 0) ? 4'b0011 : 4'b1100;
            checks++;
            if (gotn[k] != 4 || gotbits[k][3:0] !== ws) begin
                errors++;
                $display("[TB] FAIL midreset_stream dut%0d got=%0d bits %b want=4 bits %b", k, gotn[k], gotbits[k][3:0], ws);
            end
        end
    endtask

    // Random traffic on both handshakes, checked against the model each cycle.
    task automatic test_random();
        logic [4:0] got, want;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 3) == 0, 4'($urandom), ($urandom % 4) != 0);
            for (int k = 0; k < 2; k++) begin
                got = (k == 0) ? dv0 : dv1;
                want = exp_vec(k);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL random cyc%0d dut%0d vld/last/out/rdy/busy got=%b want=%b", c, k, got, want);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] starting pipo_serializer_ctrl bench");
        test_reset();
        test_single_word();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
